// File: rtl/genius_core_n.sv
// Simon ("Genius") game core: LFSR-built colour sequence, replay on leds, press checking.
// Define GENIUS_TIMEOUT_EN to make an idle INPUT phase end the game after TIMEOUT_CYC cycles.
module genius_core_n #(
  parameter int          N_BTN       = 4,
  parameter int          MAX_LEN     = 32,
  parameter int          SHOW_CYC    = 25_000_000,
  parameter int          GAP_CYC     = 12_500_000,
  parameter int          TIMEOUT_CYC = 250_000_000,
  parameter logic [15:0] SEED        = 16'hACE1,
  localparam int         IW          = (N_BTN > 2) ? $clog2(N_BTN) : 1,
  localparam int         LW          = $clog2(MAX_LEN + 1)
) (
  input  logic             clock,
  input  logic             reset,
  input  logic             start,
  input  logic [N_BTN-1:0] btn,
  output logic [N_BTN-1:0] leds,
  output logic [LW-1:0]    score,
  output logic [2:0]       state,
  output logic             win,
  output logic             lose
);

  localparam int AW   = (MAX_LEN > 1) ? $clog2(MAX_LEN) : 1;
  localparam int CMAX = (SHOW_CYC > GAP_CYC) ? SHOW_CYC : GAP_CYC;
  localparam int CW   = $clog2(CMAX + 1);
  localparam logic [CW-1:0] SHOW_LD = CW'(SHOW_CYC - 1);
  localparam logic [CW-1:0] GAP_LD  = CW'(GAP_CYC - 1);
  localparam logic [IW:0]   NB      = (IW + 1)'(N_BTN);
  localparam logic [LW-1:0] LEN_MAX = LW'(MAX_LEN);

  typedef enum logic [2:0] {
    S_IDLE     = 3'd0,
    S_SHOW_ON  = 3'd1,
    S_SHOW_OFF = 3'd2,
    S_INPUT    = 3'd3,
    S_PAUSE    = 3'd4,
    S_WIN      = 3'd5,
    S_LOSE     = 3'd6
  } state_t;

  state_t           state_q, state_d;
  logic [15:0]      lfsr_q, lfsr_d;
  logic             start_q, start_d;
  logic [N_BTN-1:0] btn_q, btn_d;
  logic [LW-1:0]    len_q, len_d;
  logic [LW-1:0]    idx_q, idx_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic [LW-1:0]    score_q, score_d;
  logic [N_BTN-1:0] leds_q, leds_d;
  logic             blink_q, blink_d;
  logic [IW-1:0]    seq_q [MAX_LEN];
  logic [IW-1:0]    seq_d [MAX_LEN];

  logic             start_edge;
  logic [N_BTN-1:0] btn_edge;
  logic [IW-1:0]    raw_sym, new_sym, cur_sym, show_sym;
  logic             last_idx;

`ifdef GENIUS_TIMEOUT_EN
  localparam int TW = $clog2(TIMEOUT_CYC + 1);
  localparam logic [TW-1:0] TMO_LAST = TW'(TIMEOUT_CYC - 1);
  logic [TW-1:0] tmo_q, tmo_d;
`endif

  function automatic logic [N_BTN-1:0] onehot(input logic [IW-1:0] s);
    logic [N_BTN-1:0] oh;
    for (int i = 0; i < N_BTN; i++) oh[i] = (s == IW'(i));
    return oh;
  endfunction

  always_comb begin
    lfsr_d     = {lfsr_q[14:0], lfsr_q[15] ^ lfsr_q[13] ^ lfsr_q[12] ^ lfsr_q[10]};
    start_d    = start;
    btn_d      = btn;
    start_edge = start & ~start_q;
    btn_edge   = btn & ~btn_q;
    // IW bits never reach 2*N_BTN, so a single conditional subtract folds the value into range
    raw_sym    = lfsr_q[IW-1:0];
    new_sym    = ({1'b0, raw_sym} >= NB) ? raw_sym - NB[IW-1:0] : raw_sym;
    cur_sym    = seq_q[idx_q[AW-1:0]];
    last_idx   = (idx_q == len_q - LW'(1));

    state_d = state_q;
    len_d   = len_q;
    idx_d   = idx_q;
    cnt_d   = (cnt_q != '0) ? cnt_q - CW'(1) : cnt_q;
    score_d = score_q;
    blink_d = blink_q;
    seq_d   = seq_q;
`ifdef GENIUS_TIMEOUT_EN
    tmo_d   = (state_q == S_INPUT) ? tmo_q + TW'(1) : '0;
`endif

    if (start_edge) begin
      seq_d[0] = new_sym;
      len_d    = LW'(1);
      idx_d    = '0;
      score_d  = '0;
      cnt_d    = SHOW_LD;
      state_d  = S_SHOW_ON;
    end else begin
      case (state_q)
        S_SHOW_ON: begin
          if (cnt_q == '0) begin
            state_d = S_SHOW_OFF;
            cnt_d   = GAP_LD;
          end
        end
        S_SHOW_OFF: begin
          if (cnt_q == '0) begin
            if (last_idx) begin
              idx_d   = '0;
              state_d = S_INPUT;
            end else begin
              idx_d   = idx_q + LW'(1);
              cnt_d   = SHOW_LD;
              state_d = S_SHOW_ON;
            end
          end
        end
        S_INPUT: begin
          if (btn_edge != '0) begin
            // Comparing against the full one-hot rejects both wrong and multiple presses
            if (btn_edge == onehot(cur_sym)) begin
`ifdef GENIUS_TIMEOUT_EN
              tmo_d = '0;
`endif
              if (!last_idx) begin
                idx_d = idx_q + LW'(1);
              end else if (len_q == LEN_MAX) begin
                score_d = len_q;
                state_d = S_WIN;
              end else begin
                score_d                = len_q;
                seq_d[len_q[AW-1:0]]   = new_sym;
                len_d                  = len_q + LW'(1);
                idx_d                  = '0;
                cnt_d                  = GAP_LD;
                state_d                = S_PAUSE;
              end
            end else begin
              blink_d = 1'b1;
              cnt_d   = GAP_LD;
              state_d = S_LOSE;
            end
`ifdef GENIUS_TIMEOUT_EN
          end else if (tmo_q == TMO_LAST) begin
            blink_d = 1'b1;
            cnt_d   = GAP_LD;
            state_d = S_LOSE;
`endif
          end
        end
        S_PAUSE: begin
          if (cnt_q == '0) begin
            idx_d   = '0;
            cnt_d   = SHOW_LD;
            state_d = S_SHOW_ON;
          end
        end
        S_LOSE: begin
          if (cnt_q == '0) begin
            blink_d = ~blink_q;
            cnt_d   = GAP_LD;
          end
        end
        default: begin
        end
      endcase
    end
  end

  // leds are registered, so they are derived from the state being entered
  always_comb begin
    show_sym = start_edge ? new_sym : seq_q[idx_d[AW-1:0]];
    leds_d   = '0;
    case (state_d)
      S_SHOW_ON: leds_d = onehot(show_sym);
      S_INPUT:   leds_d = btn;
      S_WIN:     leds_d = '1;
      S_LOSE:    leds_d = blink_d ? '1 : '0;
      default:   leds_d = '0;
    endcase
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q <= S_IDLE;
      lfsr_q  <= SEED;
      start_q <= 1'b0;
      btn_q   <= '0;
      len_q   <= '0;
      idx_q   <= '0;
      cnt_q   <= '0;
      score_q <= '0;
      leds_q  <= '0;
      blink_q <= 1'b0;
`ifdef GENIUS_TIMEOUT_EN
      tmo_q   <= '0;
`endif
    end else begin
      state_q <= state_d;
      lfsr_q  <= lfsr_d;
      start_q <= start_d;
      btn_q   <= btn_d;
      len_q   <= len_d;
      idx_q   <= idx_d;
      cnt_q   <= cnt_d;
      score_q <= score_d;
      leds_q  <= leds_d;
      blink_q <= blink_d;
`ifdef GENIUS_TIMEOUT_EN
      tmo_q   <= tmo_d;
`endif
    end
  end

  // Sequence storage survives reset; len clearing makes it unreachable
  always_ff @(posedge clock) begin
    seq_q <= seq_d;
  end

  assign leds  = leds_q;
  assign score = score_q;
  assign state = state_q;
  assign win   = (state_q == S_WIN);
  assign lose  = (state_q == S_LOSE);

endmodule

// File: tb/tb_genius_core_n.sv
// Directed bench for genius_core_n with N_BTN=3, MAX_LEN=4, SHOW_CYC=4, GAP_CYC=2, TIMEOUT_CYC=20.
module tb_genius_core_n;

  logic       clock;
  logic       reset;
  logic       start;
  logic [2:0] btn;
  logic [2:0] leds;
  logic [2:0] score;
  logic [2:0] state;
  logic       win;
  logic       lose;

  int checks = 0;
  int errors = 0;

  logic [15:0] ref_lfsr;
  logic [1:0]  exp_seq [4];

  genius_core_n #(
    .N_BTN(3), .MAX_LEN(4), .SHOW_CYC(4), .GAP_CYC(2), .TIMEOUT_CYC(20), .SEED(16'hACE1)
  ) dut (
    .clock(clock), .reset(reset), .start(start), .btn(btn),
    .leds(leds), .score(score), .state(state), .win(win), .lose(lose)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Reference 16-bit Fibonacci LFSR, taps 16,14,13,11, stepping every clock
  always @(posedge clock or posedge reset) begin
    if (reset) ref_lfsr <= 16'hACE1;
    else       ref_lfsr <= {ref_lfsr[14:0], ref_lfsr[15] ^ ref_lfsr[13] ^ ref_lfsr[12] ^ ref_lfsr[10]};
  end

  function automatic logic [1:0] refSym(input logic [15:0] l);
    logic [1:0] v;
    v = l[1:0];
    return (v >= 2'd3) ? v - 2'd3 : v;
  endfunction

  function automatic logic [2:0] oneHot(input logic [1:0] s);
    return 3'b001 << s;
  endfunction

  task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("[TB] FAIL %s observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic applyStimulus(input logic s, input logic [2:0] b);
    start = s;
    btn   = b;
  endtask

  task automatic tick(input int n);
    repeat (n) begin
      @(posedge clock);
      @(negedge clock);
    end
  endtask

  // Called on the first SHOW_ON sample; ends on the first INPUT sample
  task automatic replay(input int n);
    for (int s = 0; s < n; s++) begin
      for (int i = 0; i < 4; i++) begin
        checkOutput("show_on_state", state, 3'd1);
        checkOutput("show_on_leds", leds, oneHot(exp_seq[s]));
        tick(1);
      end
      for (int i = 0; i < 2; i++) begin
        checkOutput("show_off_state", state, 3'd2);
        checkOutput("show_off_leds", leds, 3'd0);
        tick(1);
      end
    end
    checkOutput("input_state", state, 3'd3);
    checkOutput("input_leds", leds, 3'd0);
  endtask

  // Presses all n symbols; ends on the sample right after the last press
  task automatic pressRound(input int n);
    for (int s = 0; s < n; s++) begin
      if (s == n - 1 && n < 4) exp_seq[n] = refSym(ref_lfsr);
      applyStimulus(1'b0, oneHot(exp_seq[s]));
      tick(1);
      applyStimulus(1'b0, 3'b000);
      if (s < n - 1) begin
        checkOutput("mid_press_state", state, 3'd3);
        checkOutput("press_echo", leds, oneHot(exp_seq[s]));
        tick(1);
      end
    end
  endtask

  task automatic startGame();
    exp_seq[0] = refSym(ref_lfsr);
    applyStimulus(1'b1, 3'b000);
    tick(1);
    applyStimulus(1'b0, 3'b000);
  endtask

  initial begin
    reset = 1'b1;
    applyStimulus(1'b0, 3'b000);
    tick(2);
    reset = 1'b0;
    checkOutput("rst_state", state, 3'd0);
    checkOutput("rst_leds", leds, 3'd0);
    checkOutput("rst_score", score, 3'd0);
    checkOutput("rst_win", win, 1'b0);
    checkOutput("rst_lose", lose, 1'b0);
    tick(1);

    // Reset asserted in the middle of SHOW_ON acts immediately
    startGame();
    checkOutput("pre_rst_state", state, 3'd1);
    tick(1);
    reset = 1'b1;
    #1;
    checkOutput("async_rst_state", state, 3'd0);
    checkOutput("async_rst_leds", leds, 3'd0);
    checkOutput("async_rst_score", score, 3'd0);
    @(negedge clock);
    reset = 1'b0;
    tick(1);

    // Full winning game
    startGame();
    replay(1);
    for (int r = 1; r <= 4; r++) begin
      pressRound(r);
      if (r < 4) begin
        checkOutput("pause_state", state, 3'd4);
        checkOutput("pause_score", score, 3'(r));
        checkOutput("pause_leds", leds, 3'd0);
        tick(1);
        checkOutput("pause_state2", state, 3'd4);
        tick(1);
        replay(r + 1);
      end
    end
    checkOutput("win_state", state, 3'd5);
    checkOutput("win_flag", win, 1'b1);
    checkOutput("win_leds", leds, 3'b111);
    checkOutput("win_score", score, 3'd4);
    applyStimulus(1'b0, 3'b001);
    tick(1);
    applyStimulus(1'b0, 3'b000);
    tick(1);
    checkOutput("win_btn_state", state, 3'd5);
    checkOutput("win_btn_leds", leds, 3'b111);

    // Restart from WIN, then lose with a wrong button at score 1
    startGame();
    checkOutput("restart_score", score, 3'd0);
    replay(1);
    pressRound(1);
    checkOutput("r1_score", score, 3'd1);
    tick(2);
    replay(2);
    applyStimulus(1'b0, oneHot((exp_seq[0] == 2'd2) ? 2'd0 : exp_seq[0] + 2'd1));
    tick(1);
    applyStimulus(1'b0, 3'b000);
    checkOutput("wrong_state", state, 3'd6);
    checkOutput("wrong_lose", lose, 1'b1);
    checkOutput("wrong_score", score, 3'd1);
    begin
      logic [2:0] blink_exp [5];
      blink_exp = '{3'b111, 3'b111, 3'b000, 3'b000, 3'b111};
      for (int i = 0; i < 5; i++) begin
        checkOutput("lose_blink", leds, blink_exp[i]);
        if (i < 4) tick(1);
      end
    end

    // Start during LOSE, then a double press
    startGame();
    checkOutput("lose_restart_state", state, 3'd1);
    checkOutput("lose_restart_score", score, 3'd0);
    checkOutput("lose_restart_flag", lose, 1'b0);
    replay(1);
    applyStimulus(1'b0, oneHot(exp_seq[0]) | oneHot((exp_seq[0] == 2'd2) ? 2'd0 : exp_seq[0] + 2'd1));
    tick(1);
    applyStimulus(1'b0, 3'b000);
    checkOutput("double_state", state, 3'd6);

    // Start together with a wrong press in INPUT: start wins
    startGame();
    replay(1);
    exp_seq[0] = refSym(ref_lfsr);
    applyStimulus(1'b1, oneHot((exp_seq[0] == 2'd2) ? 2'd0 : exp_seq[0] + 2'd1));
    tick(1);
    applyStimulus(1'b0, 3'b000);
    checkOutput("prio_state", state, 3'd1);
    checkOutput("prio_score", score, 3'd0);
    replay(1);

`ifdef GENIUS_TIMEOUT_EN
    tick(19);
    checkOutput("tmo_still_input", state, 3'd3);
    tick(1);
    checkOutput("tmo_lose", state, 3'd6);
`else
    tick(200);
    checkOutput("no_tmo_state", state, 3'd3);
`endif

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/genius_core_n.md
# genius_core_n

Parametrised Simon ("Genius") game core: builds a pseudo-random colour sequence one symbol per round, replays it on `leds`, then checks the player's button presses against it. It generalises the fixed 3-button game to `N_BTN` channels and a `MAX_LEN`-deep sequence, and adds win detection, restart-on-start, and an optional input timeout. It sits between the debounced button/start inputs and the LED and 7-segment display drivers. `score` feeds the seven-segment decoder.

## Interface
- `N_BTN`, 4: number of buttons/LEDs, 2..8; `IW = max(1, $clog2(N_BTN))`.
- `MAX_LEN`, 32: sequence length that wins the game, 1..256; `LW = $clog2(MAX_LEN+1)`.
- `SHOW_CYC`, 25_000_000: cycles each symbol is lit during replay.
- `GAP_CYC`, 12_500_000: dark cycles after each symbol; also the PAUSE length and the LOSE blink half-period.
- `TIMEOUT_CYC`, 250_000_000: idle cycles allowed in INPUT. Used only with `GENIUS_TIMEOUT_EN`.
- `SEED`, 16'hACE1: LFSR reset value, must be non-zero.
- `clock`  in  1  system clock, all logic on its rising edge.
- `reset`  in  1  asynchronous, active-high; forces IDLE.
- `start`  in  1  debounced level; its rising edge starts or restarts a game.
- `btn`  in  N_BTN  debounced levels; their rising edges are the presses.
- `leds`  out  N_BTN  display of the current symbol or status.
- `score`  out  LW  rounds completed in the current game.
- `state`  out  3  IDLE=0, SHOW_ON=1, SHOW_OFF=2, INPUT=3, PAUSE=4, WIN=5, LOSE=6.
- `win`  out  1  high while in WIN.
- `lose`  out  1  high while in LOSE.

## Operation
- **Reset values.** All outputs 0 and state IDLE. The LFSR loads `SEED`; len, idx, counters and edge registers clear.
- **Symbol generation.** 16-bit Fibonacci LFSR, taps 16,14,13,11, advances every cycle regardless of state. New symbol = `lfsr[IW-1:0]`, minus `N_BTN` if that value is ≥ `N_BTN`. Symbols are stored in a `MAX_LEN` x `IW` register array.
- **Edge detection.** `start` and `btn` are each registered once. An edge is input high while its registered copy is low.
- **IDLE.** `leds` = 0. On a start edge: `seq[0]` = new symbol, len = 1, idx = 0, go to SHOW_ON.
- **SHOW_ON.** `leds` = onehot(`seq[idx]`) for `SHOW_CYC` cycles, then SHOW_OFF.
- **SHOW_OFF.** `leds` = 0 for `GAP_CYC` cycles.
  - If idx == len-1: go to INPUT with idx = 0.
  - Otherwise: idx+1, back to SHOW_ON.
- **INPUT.** `leds` = `btn` echo. Each cycle with any btn edge is evaluated:
  - Exactly one edge and it equals `seq[idx]`: correct.
    - If idx < len-1: idx+1.
    - Else if len == `MAX_LEN`: score = len, go to WIN.
    - Else: score = len, `seq[len]` = new symbol, len+1, idx = 0, go to PAUSE.
  - Wrong button, or two or more edges in the same cycle: go to LOSE.
- **PAUSE.** `leds` = 0 for `GAP_CYC` cycles, then SHOW_ON with idx = 0.
- **WIN.** `leds` all ones. Stays until the next start edge.
- **LOSE.** `leds` toggles between all ones and 0 every `GAP_CYC` cycles, starting all ones. `score` holds. Stays until the next start edge.
- **Start edge in any non-IDLE state.** Aborts and restarts exactly as from IDLE: `seq[0]` new, len = 1, score = 0.
- **Priority.** A start edge wins over a simultaneous btn edge.
- **Other btn edges.** Ignored outside INPUT.
- **Reset mid-game.** Immediate return to IDLE; the sequence contents are not cleared but are unreachable.

## Timing
- An input edge sampled at clock edge t is acted on at t+1. `state`, `leds`, `score`, `win` and `lose` are registered and change at t+1.
- Per symbol, replay takes exactly `SHOW_CYC` + `GAP_CYC` cycles. Round r (len = r) replays in r·(`SHOW_CYC`+`GAP_CYC`) cycles, preceded by `GAP_CYC` PAUSE cycles for r > 1.
- A phase counter reloads on every state entry. A state with count C occupies exactly C cycles.

## Configuration
- `GENIUS_TIMEOUT_EN` defined:
  - A counter clears on INPUT entry and on every correct press.
  - If it reaches `TIMEOUT_CYC` with no press, the next state is LOSE.
- Not defined: INPUT waits indefinitely. `TIMEOUT_CYC` is unused and no counter logic is synthesised.

## Test plan
All scenarios use N_BTN=3, MAX_LEN=4, SHOW_CYC=4, GAP_CYC=2, TIMEOUT_CYC=20.
- **Reset.** Assert reset mid-SHOW_ON → same cycle `state`=0, `leds`=0, `score`=0, `win`=`lose`=0.
- **First round.** Start pulse → next cycle `state`=1 with `leds` onehot of a value < 3 for 4 cycles. Then `leds`=0 for 2 cycles, then `state`=3.
- **Correct press.** Press the shown button → `score`=1, PAUSE 2 cycles, then two symbols replayed (12 cycles), the first identical to round 1.
- **Errors.**
  - Wrong button → `state`=6 next cycle, `lose`=1, `score` unchanged, `leds` 111/000 alternating every 2 cycles.
  - Separately, two buttons pressed in the same cycle → LOSE.
  - Start during LOSE → `score`=0, SHOW_ON.
- **Win.** Complete all 4 rounds correctly → `state`=5, `win`=1, `leds`=111, `score`=4. A btn edge in WIN has no effect.
- **Timeout.**
  - With `GENIUS_TIMEOUT_EN`: no press for 20 cycles in INPUT → LOSE.
  - Without the macro: still `state`=3 after 200 cycles.
